// File: rtl/subtractor_serial_sm.sv
// subtractor_serial_sm: digit-serial sign-magnitude subtract / add with carry-out
module subtractor_serial_sm #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             sgn,
    output logic             cout
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int IW = NDIG > 1 ? $clog2(NDIG) : 1;
    typedef enum logic [1:0] {IDLE, SUB, FIX, DONE} state_t;
    state_t state, nxt;
    logic [WIDTH-1:0] a_r, b_r, acc, acc_nxt;
    logic op_r, carry, last, accept;
    logic [IW-1:0] idx;
    logic [31:0] base;
    logic [DIGIT-1:0] a_d, b_d, c_d;
    logic [DIGIT:0] sum;
    always_comb begin
        base = 32'(idx) * 32'(DIGIT);
        a_d = DIGIT'(a_r >> base);
        b_d = DIGIT'(b_r >> base);
        c_d = DIGIT'(acc >> base);
        // FIX reuses the digit adder to negate the accumulator in place
        sum = state == FIX ? {1'b0, ~c_d} + (DIGIT+1)'(carry)
                           : {1'b0, a_d} + {1'b0, op_r ? b_d : ~b_d} + (DIGIT+1)'(carry);
        acc_nxt = (acc & ~(WIDTH'({DIGIT{1'b1}}) << base)) | (WIDTH'(sum[DIGIT-1:0]) << base);
        last = idx == IW'(NDIG - 1);
        accept = start && (state == IDLE || state == DONE);
        busy = state == SUB || state == FIX;
        done = state == DONE;
        nxt = state;
        if (state == IDLE || state == DONE)
            nxt = accept ? SUB : IDLE;
        else if (last)
            nxt = state == SUB && !op_r && !sum[DIGIT] ? FIX : DONE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_r    <= '0;
            b_r    <= '0;
            op_r   <= 1'b0;
            acc    <= '0;
            carry  <= 1'b0;
            idx    <= '0;
            result <= '0;
            sgn    <= 1'b1;
            cout   <= 1'b0;
        end else begin
            state <= nxt;
            if (accept) begin
                a_r   <= a;
                b_r   <= b;
                op_r  <= op;
                idx   <= '0;
                carry <= ~op;
            end else if (busy) begin
                acc   <= acc_nxt;
                idx   <= last ? '0 : idx + 1'b1;
                carry <= state == SUB && nxt == FIX ? 1'b1 : sum[DIGIT];
            end
            if (nxt == DONE) begin
                result <= acc_nxt;
                sgn    <= state == SUB;
                cout   <= state == SUB && op_r && sum[DIGIT];
            end
        end
    end
endmodule

// File: tb/tb_subtractor_serial_sm.sv
// tb_subtractor_serial_sm: scoreboard bench, directed 8/4 corners plus random 16-bit at DIGIT 1/4/16
module tb_subtractor_serial_sm;
    typedef struct {logic [15:0] r; logic s; logic c; int t;} exp_t;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    int vecs = 0, errs = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        vecs++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic exp_t model(input int w, input bit o, input logic [31:0] x, input logic [31:0] y,
                                   input int t0, input int ndig);
        exp_t e;
        longint s;
        if (o) begin
            s = longint'(x) + longint'(y);
            e.r = 16'(s % (longint'(1) << w));
            e.c = s >= (longint'(1) << w);
            e.s = 1'b1;
            e.t = t0 + ndig;
        end else begin
            e.r = 16'(x >= y ? x - y : y - x);
            e.c = 1'b0;
            e.s = x >= y;
            e.t = t0 + (x >= y ? ndig : 2 * ndig);
        end
        return e;
    endfunction

    logic rst, start, op, busy, done, sgn, cout;
    logic [7:0] a, b, result;
    exp_t q[$];

    subtractor_serial_sm #(.WIDTH(8), .DIGIT(4)) u_dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .sgn(sgn), .cout(cout)
    );

    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (q.size() == 0) check("spurious_done_w8", done, 0);
            else begin
                e = q.pop_front();
                check("result_w8", result, e.r);
                check("sgn_w8", sgn, e.s);
                check("cout_w8", cout, e.c);
                check("latency_w8", cyc, e.t);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dissue(input bit o, input logic [7:0] x, input logic [7:0] y);
        start = 1'b1; op = o; a = x; b = y;
        tick();
        q.push_back(model(8, o, x, y, cyc, 2));
        start = 1'b0;
    endtask

    task automatic dop(input bit o, input logic [7:0] x, input logic [7:0] y, input int gap);
        dissue(o, x, y);
        repeat ((!o && x < y) ? 4 : 2) tick();
        repeat (gap) tick();
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_rnd
        localparam int D = g == 0 ? 1 : (g == 1 ? 4 : 16);
        localparam int N = 16 / D;
        logic r_rst, r_start, r_op, r_busy, r_done, r_sgn, r_cout;
        logic [15:0] r_a, r_b, r_res;
        exp_t rq[$];
        bit fin = 1'b0;

        subtractor_serial_sm #(.WIDTH(16), .DIGIT(D)) u_dut (
            .clk(clk), .rst(r_rst), .start(r_start), .op(r_op), .a(r_a), .b(r_b),
            .busy(r_busy), .done(r_done), .result(r_res), .sgn(r_sgn), .cout(r_cout)
        );

        always @(negedge clk) begin
            exp_t e;
            if (r_done) begin
                if (rq.size() == 0) check($sformatf("spurious_done_d%0d", D), r_done, 0);
                else begin
                    e = rq.pop_front();
                    check($sformatf("result_d%0d", D), r_res, e.r);
                    check($sformatf("sgn_d%0d", D), r_sgn, e.s);
                    check($sformatf("cout_d%0d", D), r_cout, e.c);
                    check($sformatf("latency_d%0d", D), cyc, e.t);
                end
            end
        end

        initial begin
            bit o;
            logic [15:0] x, y;
            r_rst = 1'b1; r_start = 1'b0; r_op = 1'b0; r_a = '0; r_b = '0;
            repeat (2) @(posedge clk);
            #1 r_rst = 1'b0;
            for (int i = 0; i < 1500; i++) begin
                o = 1'($urandom_range(0, 1));
                x = 16'($urandom);
                y = $urandom_range(0, 7) == 0 ? x : 16'($urandom);
                if (i == 0) begin o = 1'b0; x = 16'h0000; y = 16'hffff; end
                if (i == 1) begin o = 1'b1; x = 16'hffff; y = 16'h0001; end
                r_start = 1'b1; r_op = o; r_a = x; r_b = y;
                @(posedge clk);
                #1;
                rq.push_back(model(16, o, x, y, cyc, N));
                r_start = 1'b0;
                repeat ((!o && x < y) ? 2 * N : N) @(posedge clk);
                #1;
                repeat ($urandom_range(0, 1)) begin
                    @(posedge clk);
                    #1;
                end
            end
            repeat (3) @(posedge clk);
            check($sformatf("pending_d%0d", D), rq.size(), 0);
            fin = 1'b1;
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_sgn", sgn, 1);
        check("rst_cout", cout, 0);
        rst = 1'b0;
        tick();
        dissue(0, 9, 4);
        check("busy_sub0", busy, 1);
        tick();
        check("busy_sub1", busy, 1);
        tick();
        check("busy_in_done", busy, 0);
        tick();
        dop(0, 4, 9, 1);
        dop(0, 170, 170, 1);
        dop(0, 0, 255, 1);
        dop(1, 200, 100, 1);
        dop(1, 15, 1, 1);
        dissue(0, 4, 9);
        start = 1'b1; op = 1'b1; a = 8'd1; b = 8'd2;
        repeat (3) tick();
        start = 1'b0;
        repeat (2) tick();
        dop(1, 255, 1, 0);
        dop(0, 1, 2, 0);
        dop(0, 7, 3, 2);
        dissue(0, 4, 9);
        rst = 1'b1;
        tick();
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_result", result, 0);
        check("abort_sgn", sgn, 1);
        check("abort_cout", cout, 0);
        rst = 1'b0;
        q.delete(q.size() - 1);
        repeat (6) tick();
        dop(0, 100, 50, 1);
        for (int i = 0; i < 300; i++) begin
            bit o;
            logic [7:0] x, y;
            o = 1'($urandom_range(0, 1));
            x = 8'($urandom);
            y = $urandom_range(0, 5) == 0 ? x : 8'($urandom);
            dop(o, x, y, $urandom_range(0, 1));
        end
        repeat (2) tick();
        check("pending_w8", q.size(), 0);
        while (!(g_rnd[0].fin && g_rnd[1].fin && g_rnd[2].fin) && cyc < 95000) @(posedge clk);
        check("random_finished", {g_rnd[0].fin, g_rnd[1].fin, g_rnd[2].fin}, 3'b111);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
